sched_task_selector: RTL and testbench

SCHED_TASK_SELECTOR -- requirements
Module: sched_task_selector

---
 rtl/sched_task_selector.sv | 155 +++++++++++++++
 tb/tb_sched_task_selector.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sched_task_selector.sv
`default_nettype none
// sched_task_selector: tick/yield-driven priority scan, one task per cycle, with switch_req/ack handshake.
// Define SCHED_ROUND_ROBIN_EN to start each scan after cur_task_id so equal priorities rotate.
module sched_task_selector #(
  parameter int NUM_TASKS = 8,
  parameter int PRIO_W    = 3,
  parameter int TICK_DIV  = 1000
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         sched_en,
  input  logic [NUM_TASKS-1:0]         rdy_set,
  input  logic [NUM_TASKS-1:0]         rdy_clr,
  input  logic                         prio_we,
  input  logic [$clog2(NUM_TASKS)-1:0] prio_idx,
  input  logic [PRIO_W-1:0]            prio_wdata,
  input  logic                         yield,
  input  logic                         switch_ack,
  output logic                         switch_req,
  output logic [$clog2(NUM_TASKS)-1:0] next_task_id,
  output logic [$clog2(NUM_TASKS)-1:0] cur_task_id,
  output logic [NUM_TASKS-1:0]         ready_mask,
  output logic                         busy
);
  localparam int ID_W  = $clog2(NUM_TASKS);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_TASKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic              pending;
  logic [PRIO_W-1:0] prio_tbl [NUM_TASKS];
  logic [ID_W-1:0]   scan_ptr;
  logic [ID_W-1:0]   scan_k;
  logic [ID_W-1:0]   scan_start;
  logic [ID_W-1:0]   cand_idx;
  logic [PRIO_W-1:0] cand_prio;
  logic              cand_vld;
  logic              hit;
  logic              fin_vld;
  logic [ID_W-1:0]   fin_idx;

  assign tick = sched_en && (tick_cnt == CNT_LAST);

`ifdef SCHED_ROUND_ROBIN_EN
  assign scan_start = cur_task_id + ID_W'(1);
`else
  assign scan_start = '0;
`endif

  // Only a strictly higher priority displaces the candidate, so the earliest-scanned task wins ties.
  assign hit     = ready_mask[scan_ptr] && (!cand_vld || (prio_tbl[scan_ptr] > cand_prio));
  assign fin_vld = cand_vld || hit;
  assign fin_idx = hit ? scan_ptr : cand_idx;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tick_cnt <= '0;
    end else if (!sched_en || tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_mask <= '0;
    end else begin
      ready_mask <= (ready_mask | rdy_set) & ~rdy_clr;
    end
  end

  // The scan reads the table live, so a write lands only if its entry has not been visited yet.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_TASKS; i++) prio_tbl[i] <= '0;
    end else if (prio_we) begin
      prio_tbl[prio_idx] <= prio_wdata;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= IDLE;
      busy         <= 1'b0;
      switch_req   <= 1'b0;
      next_task_id <= '0;
      cur_task_id  <= '0;
      pending      <= 1'b0;
      scan_ptr     <= '0;
      scan_k       <= '0;
      cand_vld     <= 1'b0;
      cand_idx     <= '0;
      cand_prio    <= '0;
    end else begin
      if (state != IDLE && (tick || yield)) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (sched_en && (tick || yield || pending)) begin
            state     <= SCAN;
            busy      <= 1'b1;
            pending   <= 1'b0;
            scan_ptr  <= scan_start;
            scan_k    <= '0;
            cand_vld  <= 1'b0;
            cand_idx  <= '0;
            cand_prio <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            cand_vld  <= 1'b1;
            cand_idx  <= scan_ptr;
            cand_prio <= prio_tbl[scan_ptr];
          end
          scan_ptr <= scan_ptr + ID_W'(1);
          scan_k   <= scan_k + ID_W'(1);
          if (scan_k == ID_LAST) begin
            if (fin_vld && fin_idx != cur_task_id) begin
              state        <= REQ;
              next_task_id <= fin_idx;
              switch_req   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        REQ: begin
          if (switch_ack) begin
            cur_task_id <= next_task_id;
            switch_req  <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          switch_req <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sched_task_selector.sv
`default_nettype none
// tb_sched_task_selector: directed stimulus, per-cycle comparison against a behavioural scheduler model.
module tb_sched_task_selector;
  localparam int N  = 8;
  localparam int PW = 3;
  localparam int TD = 16;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic         sched_en = 1'b0;
  logic [N-1:0] rdy_set = '0;
  logic [N-1:0] rdy_clr = '0;
  logic         prio_we = 1'b0;
  logic [2:0]   prio_idx = '0;
  logic [PW-1:0] prio_wdata = '0;
  logic         yield = 1'b0;
  logic         switch_ack = 1'b0;
  logic         switch_req;
  logic [2:0]   next_task_id;
  logic [2:0]   cur_task_id;
  logic [N-1:0] ready_mask;
  logic         busy;

  int errors = 0;
  int checks = 0;

  sched_task_selector #(.NUM_TASKS(N), .PRIO_W(PW), .TICK_DIV(TD)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .sched_en(sched_en), .rdy_set(rdy_set), .rdy_clr(rdy_clr),
    .prio_we(prio_we), .prio_idx(prio_idx), .prio_wdata(prio_wdata), .yield(yield),
    .switch_ack(switch_ack), .switch_req(switch_req), .next_task_id(next_task_id),
    .cur_task_id(cur_task_id), .ready_mask(ready_mask), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 scanning, 2 requesting.
  int           m_phase = 0;
  int           m_pos = 0;
  int           m_start = 0;
  int           m_cur = 0;
  int           m_next = 0;
  int           m_en = 0;
  bit           m_pend = 0;
  logic [N-1:0] m_ready = '0;
  int           m_prio [N];
  bit           seen_rdy [N];
  int           seen_prio [N];

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_cur = 0; m_next = 0; m_en = 0; m_pend = 0; m_ready = '0;
    for (int i = 0; i < N; i++) m_prio[i] = 0;
  endtask

  // Highest ready priority wins; among equals the one visited first.
  task automatic pick(output int win, output bit ok);
    int best;
    best = -1; ok = 0; win = 0;
    for (int k = 0; k < N; k++) if (seen_rdy[k] && seen_prio[k] > best) best = seen_prio[k];
    for (int k = N - 1; k >= 0; k--)
      if (seen_rdy[k] && seen_prio[k] == best) begin
        win = (m_start + k) % N;
        ok = 1;
      end
  endtask

  task automatic model_step();
    bit ev;
    bit ok;
    int t;
    int win;
    ev = (sched_en && (m_en % TD) == TD - 1) || yield;
    case (m_phase)
      0: if (sched_en && (ev || m_pend)) begin
        m_phase = 1; m_pos = 0; m_pend = 0;
`ifdef SCHED_ROUND_ROBIN_EN
        m_start = (m_cur + 1) % N;
`else
        m_start = 0;
`endif
      end
      1: begin
        if (ev) m_pend = 1;
        t = (m_start + m_pos) % N;
        seen_rdy[m_pos] = m_ready[t];
        seen_prio[m_pos] = m_prio[t];
        m_pos++;
        if (m_pos == N) begin
          pick(win, ok);
          if (ok && win != m_cur) begin m_next = win; m_phase = 2; end
          else m_phase = 0;
        end
      end
      default: begin
        if (ev) m_pend = 1;
        if (switch_ack) begin m_cur = m_next; m_phase = 0; end
      end
    endcase
    m_ready = (m_ready | rdy_set) & ~rdy_clr;
    if (prio_we) m_prio[prio_idx] = int'(prio_wdata);
    m_en = sched_en ? m_en + 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge ACLK or posedge ARESET);
      if (ARESET) model_reset();
      else model_step();
    end
  end

  always @(negedge ACLK) begin
    if (!ARESET) begin
      chk("model_switch_req", int'(switch_req), int'(m_phase == 2));
      chk("model_busy", int'(busy), int'(m_phase != 0));
      chk("model_next_task_id", int'(next_task_id), m_next);
      chk("model_cur_task_id", int'(cur_task_id), m_cur);
      chk("model_ready_mask", int'(ready_mask), int'(m_ready));
    end
  end

  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  task automatic prio_write(input int idx, input int val);
    prio_we = 1'b1; prio_idx = 3'(idx); prio_wdata = PW'(val);
    cyc();
    prio_we = 1'b0;
  endtask

  task automatic pulse_set(input logic [N-1:0] m);
    rdy_set = m; cyc(); rdy_set = '0;
  endtask

  task automatic pulse_clr(input logic [N-1:0] m);
    rdy_clr = m; cyc(); rdy_clr = '0;
  endtask

  task automatic ack();
    switch_ack = 1'b1; cyc(); switch_ack = 1'b0;
  endtask

  task automatic wait_req(input int bound, output bit got);
    got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      cyc();
      if (switch_req) got = 1;
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) cyc();
    chk("reach_idle", int'(busy), 0);
  endtask

  initial begin
    bit got;
    int busy_cnt;
    int req_cnt;
    int rises;
    bit prev;
    int seq [4];
    seq = '{3, 5, 1, 3};

    repeat (2) cyc();
    ARESET = 1'b0;
    cyc();
    chk("rst_switch_req", int'(switch_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur", int'(cur_task_id), 0);
    chk("rst_next", int'(next_task_id), 0);
    chk("rst_ready", int'(ready_mask), 0);

    // Tasks 2 (prio 5) and 6 (prio 3): request arrives 24 edges after enabling.
    prio_write(2, 5);
    prio_write(6, 3);
    pulse_set(8'b0100_0100);
    sched_en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      cyc();
      if (i == 23) chk("lat_req_early", int'(switch_req), 0);
      if (i == 24) begin
        chk("lat_req_on_time", int'(switch_req), 1);
        chk("lat_next", int'(next_task_id), 2);
      end
    end
    ack();
    chk("ack_cur", int'(cur_task_id), 2);
    chk("ack_req_drop", int'(switch_req), 0);

    // Simultaneous set and clear: clear wins.
    rdy_set = 8'h10; rdy_clr = 8'h10;
    cyc();
    rdy_set = '0; rdy_clr = '0;
    chk("set_clr_bit4", int'(ready_mask), 8'b0100_0100);

    // Empty ready mask: one 8-cycle scan, no request.
    sched_en = 1'b0;
    wait_idle(12);
    pulse_clr(8'hFF);
    chk("mask_cleared", int'(ready_mask), 0);
    sched_en = 1'b1;
    busy_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (busy) busy_cnt++;
      if (switch_req) req_cnt++;
    end
    chk("empty_busy_cycles", busy_cnt, 8);
    chk("empty_no_req", req_cnt, 0);

    // Events during a withheld request collapse into one further scan.
    sched_en = 1'b0;
    wait_idle(12);
    prio_write(6, 7);
    pulse_set(8'b0100_0100);
    sched_en = 1'b1;
    wait_req(40, got);
    chk("hold_req_seen", int'(got), 1);
    chk("hold_next", int'(next_task_id), 6);
    yield = 1'b1; cyc(); yield = 1'b0;
    repeat (34) cyc();
    chk("hold_req_kept", int'(switch_req), 1);
    for (int i = 0; i < 20 && (m_en % TD) != 0; i++) cyc();
    prev = busy;
    switch_ack = 1'b1;
    rises = 0;
    for (int i = 0; i < 13; i++) begin
      cyc();
      switch_ack = 1'b0;
      if (busy && !prev) rises++;
      prev = busy;
    end
    chk("hold_one_rescan", rises, 1);
    chk("hold_cur", int'(cur_task_id), 6);

    // Equal priorities on tasks 1, 3, 5.
    sched_en = 1'b0;
    wait_idle(12);
    pulse_clr(8'hFF);
    prio_write(1, 4);
    prio_write(3, 4);
    prio_write(5, 4);
    pulse_set(8'b0010_1010);
    sched_en = 1'b1;
    wait_req(40, got);
    chk("tie_first_req", int'(got), 1);
    chk("tie_first_next", int'(next_task_id), 1);
    ack();
`ifdef SCHED_ROUND_ROBIN_EN
    for (int s = 0; s < 4; s++) begin
      wait_req(40, got);
      chk("rr_req_seen", int'(got), 1);
      chk("rr_next", int'(next_task_id), seq[s]);
      if (s < 3) ack();
    end
`else
    wait_req(40, got);
    chk("fixed_no_switch", int'(got), 0);
    chk("fixed_cur", int'(cur_task_id), 1);
    prio_write(5, 7);
    wait_req(40, got);
    chk("fixed_req_seen", int'(got), 1);
    chk("fixed_next", int'(next_task_id), 5);
`endif

    // Reset while a request is outstanding.
    ARESET = 1'b1;
    #1;
    chk("arst_req", int'(switch_req), 0);
    chk("arst_ready", int'(ready_mask), 0);
    chk("arst_cur", int'(cur_task_id), 0);
    chk("arst_busy", int'(busy), 0);
    cyc();
    ARESET = 1'b0;
    repeat (4) cyc();
    chk("post_rst_next", int'(next_task_id), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
